mem_bus_ctrl: RTL

//  Bus initiator for the MCU's on-chip 16-bit strobe-style data RAM (ports data/q/addr/cs/we/re).

---
 rtl/mem_bus_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU load/store to strobe-style RAM bus initiator.
// Drives cs/we/re with programmable setup/strobe/hold timing and returns load
// data with a one-cycle response pulse.
// Optional feature macro: MEM_BUS_RDBACK_EN (store readback verify, drives wr_err).
module mem_bus_ctrl #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          wr_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          op_we, op_we_nx;   // latched request direction
    logic          rb, rb_nx;         // readback phase of a store in progress
    logic          mis, mis_nx;       // readback data mismatch seen
    logic          req_ready_nx, resp_valid_nx, wr_err_nx;
    logic [DW-1:0] resp_rdata_nx;
    logic [AW-1:0] ram_addr_nx;
    logic [DW-1:0] ram_data_nx;
    logic          ram_cs_nx, ram_we_nx, ram_re_nx;

    // next-state and next-output logic; every output comes straight from a flop
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        op_we_nx      = op_we;
        rb_nx         = rb;
        mis_nx        = mis;
        req_ready_nx  = req_ready;
        resp_valid_nx = 1'b0;
        wr_err_nx     = 1'b0;
        resp_rdata_nx = resp_rdata;
        ram_addr_nx   = ram_addr;
        ram_data_nx   = ram_data;
        ram_cs_nx     = ram_cs;
        ram_we_nx     = 1'b0;
        ram_re_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx     = SETUP;
                    cnt_nx       = SETUP_LD;
                    op_we_nx     = req_we;
                    rb_nx        = 1'b0;
                    mis_nx       = 1'b0;
                    ram_addr_nx  = req_addr;
                    ram_data_nx  = req_wdata;
                    ram_cs_nx    = 1'b1;
                    req_ready_nx = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nx  = STROBE;
                    cnt_nx    = STROBE_LD;
                    ram_we_nx = op_we & ~rb;
                    ram_re_nx = ~op_we | rb;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx    = cnt - 4'd1;
                    ram_we_nx = op_we & ~rb;
                    ram_re_nx = ~op_we | rb;
                end
            end
            HOLD: begin
                // q is sampled at the edge closing the first hold cycle
                if (cnt == HOLD_LD) begin
                    if (rb)
                        mis_nx = (ram_q != ram_data);
                    else if (!op_we)
                        resp_rdata_nx = ram_q;
                end
                if (cnt == 4'd0) begin
`ifdef MEM_BUS_RDBACK_EN
                    if (op_we && !rb) begin
                        // keep cs asserted and read the same address back
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                        rb_nx    = 1'b1;
                    end else begin
                        state_nx      = IDLE;
                        ram_cs_nx     = 1'b0;
                        resp_valid_nx = 1'b1;
                        req_ready_nx  = 1'b1;
                        wr_err_nx     = mis_nx;
                    end
`else
                    state_nx      = IDLE;
                    ram_cs_nx     = 1'b0;
                    resp_valid_nx = 1'b1;
                    req_ready_nx  = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx     = IDLE;
                ram_cs_nx    = 1'b0;
                req_ready_nx = 1'b1;
            end
        endcase
    end

    // state and output registers; reset drops strobes and cs asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_we      <= 1'b0;
            rb         <= 1'b0;
            mis        <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            wr_err     <= 1'b0;
            resp_rdata <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            op_we      <= op_we_nx;
            rb         <= rb_nx;
            mis        <= mis_nx;
            req_ready  <= req_ready_nx;
            resp_valid <= resp_valid_nx;
            wr_err     <= wr_err_nx;
            resp_rdata <= resp_rdata_nx;
            ram_addr   <= ram_addr_nx;
            ram_data   <= ram_data_nx;
            ram_cs     <= ram_cs_nx;
            ram_we     <= ram_we_nx;
            ram_re     <= ram_re_nx;
        end
    end

endmodule
